// File: rtl/oci_trace_pkg.sv
// Shared types and constants for the OCI trace buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

    localparam int MODE_STOP = 0;  // full FIFO discards the newest word
    localparam int MODE_WRAP = 1;  // full FIFO overwrites the oldest word

    localparam int DEF_WORD_W = 30;
    localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/oci_trace_fifo_core.sv
// Register-array FIFO with occupancy count and optional overwrite-oldest on full.
// Latency: a word written at edge N is on rd_data after edge N (first-word-fall-through).
// Backpressure: none upstream; when full, push either drops or overwrites (WRAP_MODE).
//
// Ports: clk/reset (sync, active-high); push/wr_data write side; pop/rd_data read side;
//        count = occupancy 0..DEPTH; empty; wrote = word stored this cycle;
//        dropped = push lost (stop mode) or oldest lost (wrap mode).
module oci_trace_fifo_core
    import oci_trace_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = $clog2(DEPTH + 1),
    parameter int WRAP_MODE = MODE_STOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              pop,
    output logic [WORD_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              wrote,
    output logic              dropped
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_pop;
    logic              overwrite;
    logic              adv_rd;
    logic              cnt_inc;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // A simultaneous pop frees a slot, so push into a full FIFO with pop is lossless.
    assign do_pop    = pop & ~empty;
    assign dropped   = push & full & ~do_pop;
    assign overwrite = dropped & (WRAP_MODE == MODE_WRAP);
    assign wrote     = push & (~full | do_pop | overwrite);
    // Overwrite retires the oldest entry by moving the read pointer past it.
    assign adv_rd    = do_pop | overwrite;
    // Overwrite stores a word but occupancy stays at DEPTH.
    assign cnt_inc   = wrote & ~overwrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Cleared so the fall-through read port shows zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wrote) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (adv_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({cnt_inc, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/oci_trace_buffer.sv
// OCI trace sink: captures trace words into a FIFO, streams them out, counts drops, runs end-of-test drain.
// Latency: pushed word visible on out_valid/out_data one edge after capture (zero-bubble FWFT).
// Backpressure: out_ready stalls the output; trace source cannot stall, so overflow drops or overwrites.
//
// Ports: clk, reset (sync, active-high); enable starts capture from IDLE;
//        trace_valid/trace_data from CPU OCI port; out_valid/out_data/out_ready consumer stream;
//        dct_buffer = last accepted word; dct_count = occupancy; drop_count = saturating drops;
//        test_ending requests drain; test_has_ended is sticky once drained.
module oci_trace_buffer
    import oci_trace_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = $clog2(DEPTH + 1),
    parameter int DROP_W    = 16,
    parameter int WRAP_MODE = MODE_STOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              trace_valid,
    input  logic [WORD_W-1:0] trace_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic [WORD_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic [DROP_W-1:0] drop_count,
    input  logic              test_ending,
    output logic              test_has_ended
);

    trace_state_t state_q;
    trace_state_t state_d;

    logic push;
    logic pop;
    logic fifo_empty;
    logic fifo_wrote;
    logic fifo_dropped;

    // Pushes only while capturing; DRAIN ignores trace_valid entirely.
    assign push      = trace_valid & (state_q == ST_CAPTURE);
    assign out_valid = ~fifo_empty & ((state_q == ST_CAPTURE) | (state_q == ST_DRAIN));
    assign pop       = out_valid & out_ready;

    oci_trace_fifo_core #(
        .WORD_W    (WORD_W),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (trace_data),
        .pop     (pop),
        .rd_data (out_data),
        .count   (dct_count),
        .empty   (fifo_empty),
        .wrote   (fifo_wrote),
        .dropped (fifo_dropped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // IDLE is only reached through reset, so the buffer is empty here.
                if (test_ending) begin
                    state_d = ST_DONE;
                end else if (enable) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (test_ending) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish on the same edge that pops the last word.
                if (fifo_empty || (dct_count == CNT_W'(1) && pop)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign test_has_ended = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
            dct_buffer <= '0;
        end else begin
            if (fifo_dropped && (drop_count != {DROP_W{1'b1}})) begin
                drop_count <= drop_count + DROP_W'(1);
            end
            if (fifo_wrote) begin
                dct_buffer <= trace_data;
            end
        end
    end

endmodule

// File: tb/tb_oci_trace_buffer.sv
// Self-checking bench: stop-mode and wrap-mode instances driven by identical stimulus,
// each with its own expected-output queue checked by a monitor on every accepted output word.
module tb_oci_trace_buffer;
    import oci_trace_pkg::*;

    localparam int WORD_W = 30;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              trace_valid = 1'b0;
    logic [WORD_W-1:0] trace_data = '0;
    logic              out_ready = 1'b0;
    logic              test_ending = 1'b0;

    logic              ov0, ov1;
    logic [WORD_W-1:0] od0, od1;
    logic [WORD_W-1:0] db0, db1;
    logic [CNT_W-1:0]  cnt0, cnt1;
    logic [DROP_W-1:0] drp0, drp1;
    logic              end0, end1;

    logic [WORD_W-1:0] q0[$];
    logic [WORD_W-1:0] q1[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int mon_checks = 0;
    int mon_fail   = 0;

    always #5 clk = ~clk;

    oci_trace_buffer #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_W(DROP_W), .WRAP_MODE(MODE_STOP)
    ) dut_stop (
        .clk(clk), .reset(reset), .enable(enable),
        .trace_valid(trace_valid), .trace_data(trace_data),
        .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
        .dct_buffer(db0), .dct_count(cnt0), .drop_count(drp0),
        .test_ending(test_ending), .test_has_ended(end0)
    );

    oci_trace_buffer #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_W(DROP_W), .WRAP_MODE(MODE_WRAP)
    ) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable),
        .trace_valid(trace_valid), .trace_data(trace_data),
        .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
        .dct_buffer(db1), .dct_count(cnt1), .drop_count(drp1),
        .test_ending(test_ending), .test_has_ended(end1)
    );

    // Monitor: every accepted output word must match the head of its expected queue.
    always @(negedge clk) begin
        if (!reset && ov0 && out_ready) begin
            mon_checks++;
            if (q0.size() == 0) begin
                mon_fail++;
                $display("FAIL stop_out_unexpected: got word %h, required no output", od0);
            end else if (od0 !== q0[0]) begin
                mon_fail++;
                $display("FAIL stop_out_data: got %h, required %h", od0, q0[0]);
                void'(q0.pop_front());
            end else begin
                void'(q0.pop_front());
            end
        end
        if (!reset && ov1 && out_ready) begin
            mon_checks++;
            if (q1.size() == 0) begin
                mon_fail++;
                $display("FAIL wrap_out_unexpected: got word %h, required no output", od1);
            end else if (od1 !== q1[0]) begin
                mon_fail++;
                $display("FAIL wrap_out_data: got %h, required %h", od1, q1[0]);
                void'(q1.pop_front());
            end else begin
                void'(q1.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable      = 1'b0;
        trace_valid = 1'b0;
        trace_data  = '0;
        out_ready   = 1'b0;
        test_ending = 1'b0;
    endtask

    task automatic do_reset();
        chk("stop_queue_drained", q0.size(), 0);
        chk("wrap_queue_drained", q1.size(), 0);
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic start_capture();
        enable = 1'b1;
        cyc();
        enable = 1'b0;
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        trace_valid = 1'b1;
        trace_data  = w;
        cyc();
        trace_valid = 1'b0;
    endtask

    task automatic pop_cycles(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stop_out_valid"}, ov0, 0);
        chk({tag, "_stop_out_data"}, od0, 0);
        chk({tag, "_stop_dct_buffer"}, db0, 0);
        chk({tag, "_stop_dct_count"}, cnt0, 0);
        chk({tag, "_stop_drop_count"}, drp0, 0);
        chk({tag, "_stop_ended"}, end0, 0);
        chk({tag, "_wrap_out_valid"}, ov1, 0);
        chk({tag, "_wrap_out_data"}, od1, 0);
        chk({tag, "_wrap_dct_count"}, cnt1, 0);
        chk({tag, "_wrap_ended"}, end1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle_inputs();
        cyc();
        cyc();
        chk_reset_vals("reset");
        reset = 1'b0;

        // Two pushes, no pop: FWFT head is the first word
        start_capture();
        push_word(30'h0000001);
        push_word(30'h0000002);
        chk("t1_count", cnt0, 2);
        chk("t1_dct_buffer", db0, 30'h0000002);
        chk("t1_out_data", od0, 30'h0000001);
        chk("t1_out_valid", ov0, 1);
        q0.push_back(30'h1); q0.push_back(30'h2);
        q1.push_back(30'h1); q1.push_back(30'h2);
        pop_cycles(2);
        chk("t1_count_after_pop", cnt0, 0);

        // Overflow: 10 words into 8 entries
        do_reset();
        start_capture();
        for (int i = 1; i <= 10; i++) push_word(WORD_W'(i));
        chk("t2_stop_count", cnt0, 8);
        chk("t2_wrap_count", cnt1, 8);
        chk("t2_stop_drops", drp0, 2);
        chk("t2_wrap_drops", drp1, 2);
        chk("t2_stop_dct_buffer", db0, 8);
        chk("t2_wrap_dct_buffer", db1, 10);
        chk("t2_wrap_head", od1, 3);
        for (int i = 1; i <= 8; i++) q0.push_back(WORD_W'(i));
        for (int i = 3; i <= 10; i++) q1.push_back(WORD_W'(i));
        pop_cycles(8);
        chk("t2_stop_empty", cnt0, 0);
        chk("t2_wrap_empty", cnt1, 0);
        chk("t2_stop_out_valid", ov0, 0);

        // Full FIFO with simultaneous push and pop: no drops, order preserved
        do_reset();
        start_capture();
        for (int i = 0; i < 8; i++) push_word(WORD_W'(30'h11 + i));
        for (int i = 0; i < 8; i++) begin
            q0.push_back(WORD_W'(30'h11 + i));
            q1.push_back(WORD_W'(30'h11 + i));
        end
        for (int i = 0; i < 5; i++) begin
            q0.push_back(WORD_W'(30'h21 + i));
            q1.push_back(WORD_W'(30'h21 + i));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            trace_valid = 1'b1;
            trace_data  = WORD_W'(30'h21 + i);
            cyc();
            chk("t4_stop_count_full", cnt0, 8);
            chk("t4_wrap_count_full", cnt1, 8);
        end
        trace_valid = 1'b0;
        chk("t4_stop_drops", drp0, 0);
        chk("t4_wrap_drops", drp1, 0);
        pop_cycles(8);
        chk("t4_stop_empty", cnt0, 0);

        // Drain handshake: word in the test_ending cycle is kept, later trace ignored
        do_reset();
        start_capture();
        push_word(30'h31);
        push_word(30'h32);
        push_word(30'h33);
        test_ending = 1'b1;
        trace_valid = 1'b1;
        trace_data  = 30'hAB;
        cyc();
        test_ending = 1'b0;
        trace_data  = 30'h3FF;
        chk("t5_count", cnt0, 4);
        chk("t5_dct_buffer", db0, 30'hAB);
        q0.push_back(30'h31); q0.push_back(30'h32); q0.push_back(30'h33); q0.push_back(30'hAB);
        q1.push_back(30'h31); q1.push_back(30'h32); q1.push_back(30'h33); q1.push_back(30'hAB);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_not_ended_yet", end0, 0);
        end
        cyc();
        chk("t5_stop_ended", end0, 1);
        chk("t5_wrap_ended", end1, 1);
        chk("t5_count_zero", cnt0, 0);
        for (int i = 0; i < 4; i++) cyc();
        chk("t5_no_drops", drp0, 0);
        chk("t5_ended_sticky", end0, 1);
        chk("t5_done_out_valid", ov0, 0);
        chk("t5_dct_buffer_held", db0, 30'hAB);
        idle_inputs();

        // Reset during DRAIN with 5 words queued
        do_reset();
        start_capture();
        for (int i = 0; i < 5; i++) push_word(WORD_W'(30'h41 + i));
        test_ending = 1'b1;
        cyc();
        test_ending = 1'b0;
        chk("t6_count_before", cnt0, 5);
        chk("t6_out_valid_draining", ov0, 1);
        reset = 1'b1;
        cyc();
        chk_reset_vals("t6");
        reset = 1'b0;
        // IDLE: trace ignored without enable
        trace_valid = 1'b1;
        trace_data  = 30'h55;
        cyc();
        cyc();
        trace_valid = 1'b0;
        chk("t6_idle_ignores_trace", cnt0, 0);
        chk("t6_idle_no_drop", drp0, 0);
        // IDLE with test_ending goes straight to DONE
        test_ending = 1'b1;
        cyc();
        test_ending = 1'b0;
        chk("t6_idle_to_done", end0, 1);
        chk("t6_idle_to_done_wrap", end1, 1);

        chk("final_stop_queue", q0.size(), 0);
        chk("final_wrap_queue", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks + mon_checks, n_fail + mon_fail);
        $finish;
    end

endmodule

// File: doc/oci_trace_buffer.md
Name: oci_trace_buffer

Overview:
Parametrised successor to the on-chip-instrumentation test-bench sink. It captures CPU debug-trace words into a small FIFO, streams them out on a valid/ready port, and counts dropped words. It runs an end-of-test drain handshake: test_ending stops capture, the buffer empties, then test_has_ended asserts. It sits between the CPU OCI trace port, which cannot stall, and the simulation/debug consumer.

Parameters:
WORD_W, 30, trace word width (matches the existing dct_buffer width)
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (4 at default)
DROP_W, 16, drop-counter width
WRAP_MODE, 0, 0 = stop-on-full (discard newest); 1 = overwrite oldest

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  start capture (level, sampled in IDLE)
trace_valid  in  1  trace word present this cycle; the source never stalls
trace_data  in  WORD_W  trace word
out_valid  out  1  head word available
out_data  out  WORD_W  head word (first-word-fall-through)
out_ready  in  1  consumer accepts head word
dct_buffer  out  WORD_W  most recently accepted trace word
dct_count  out  CNT_W  current occupancy, 0..DEPTH
drop_count  out  DROP_W  dropped words, saturating
test_ending  in  1  request end of test
test_has_ended  out  1  drain complete, sticky

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high: it is sampled on the rising edge of clk while reset=1.
- Reset values: out_valid=0, out_data=0, dct_buffer=0, dct_count=0, drop_count=0, test_has_ended=0. FSM=IDLE, pointers=0.
- Reset asserted mid-operation, including during DRAIN, discards all contents and returns to IDLE on the next edge.
- States:
  - IDLE: trace ignored.
    - enable=1 -> CAPTURE.
    - test_ending=1 in IDLE (buffer empty) -> DONE directly.
  - CAPTURE: push when trace_valid=1.
    - test_ending=1 -> DRAIN. A trace word presented in the same cycle is still accepted.
  - DRAIN: no pushes; trace_valid ignored and not counted as dropped.
    - When dct_count reaches 0 (including the cycle the last word pops) -> DONE.
  - DONE: test_has_ended=1, held until reset. out_valid=0. enable and test_ending are ignored.
- Push/pop:
  - pop = out_valid & out_ready. push = trace_valid in CAPTURE.
  - out_valid = (dct_count != 0) and state in {CAPTURE, DRAIN}.
  - out_data = mem[rd_ptr], combinational from the register array.
  - Latency: a word pushed at edge N is visible on out_valid/out_data after edge N (zero-bubble FWFT).
  - dct_buffer updates on every accepted push; it is not updated on a drop in stop mode.
- Full, with push and no pop:
  - WRAP_MODE=0: new word discarded; drop_count+1.
  - WRAP_MODE=1: new word written at wr_ptr, rd_ptr advances (oldest lost), count stays DEPTH, drop_count+1, dct_buffer updates.
- Full, with push and pop in the same cycle: both occur, count unchanged, no drop, in either mode.
- Empty, with push and pop in the same cycle: impossible, since out_valid=0 when empty; the push proceeds normally.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. dct_count saturates at DEPTH by construction.
- drop_count saturates at 2^DROP_W-1; it never wraps.

Decomposition:
- Shared package oci_trace_pkg:
  - FSM state typedef (IDLE, CAPTURE, DRAIN, DONE).
  - Mode constants MODE_STOP=0, MODE_WRAP=1.
  - Default WORD_W/DEPTH constants.
- One sub-module, oci_trace_fifo_core: register array plus pointers, count, full/empty, and push/pop/overwrite logic.
- The top level holds the FSM, the drop counter, the dct_buffer register and the drain handshake.

Test Plan:
- Reset, then enable=1 and push 0x0000001, 0x0000002 with out_ready=0 -> dct_count=2, dct_buffer=0x0000002, out_data=0x0000001, out_valid=1.
- WRAP_MODE=0, DEPTH=8, push 10 words 1..10 with out_ready=0 -> dct_count=8, drop_count=2; pops return 1..8; dct_buffer=8.
- WRAP_MODE=1, same stimulus -> dct_count=8, drop_count=2; pops return 3..10; dct_buffer=10.
- Full FIFO, out_ready=1 and trace_valid=1 for 5 cycles -> dct_count stays 8, drop_count=0, output order preserved.
- With 3 words queued, pulse test_ending (plus trace_valid=1 with word 0xAB in the same cycle), then out_ready=1 -> 4 words out (last 0xAB); test_has_ended=1 on the edge the 4th pops; later trace_valid is not counted as dropped.
- Assert reset during DRAIN with 5 words queued -> next cycle all outputs are at their reset values and the FSM is in IDLE.
